// File: rtl/mul_issue_arbiter_if.sv
// Issue/multiplier/writeback bundle for the shared multiplier arbiter.
// Master is the surrounding core (requesters, multiplier array, writeback); slave is the arbiter.
// Request slots use valid/ready, the multiplier path is fixed-latency, writeback uses valid/ready.
interface mul_issue_arbiter_if #(
  parameter int TAG_W = 6
);
  logic             req0_valid;
  logic             req0_ready;
  logic [5:0]       req0_op;
  logic [31:0]      req0_x;
  logic [31:0]      req0_y;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [5:0]       req1_op;
  logic [31:0]      req1_x;
  logic [31:0]      req1_y;
  logic [TAG_W-1:0] req1_tag;

  logic [31:0]      mul_x;
  logic [31:0]      mul_y;
  logic             mul_signed;
  logic [31:0]      prod_s_hi;
  logic [31:0]      prod_s_lo;
  logic [31:0]      prod_u_hi;
  logic [31:0]      prod_u_lo;

  logic             wb_valid;
  logic             wb_ready;
  logic [31:0]      wb_hi;
  logic [31:0]      wb_lo;
  logic [TAG_W-1:0] wb_tag;

  modport master (
    output req0_valid, req0_op, req0_x, req0_y, req0_tag,
    input  req0_ready,
    output req1_valid, req1_op, req1_x, req1_y, req1_tag,
    input  req1_ready,
    input  mul_x, mul_y, mul_signed,
    output prod_s_hi, prod_s_lo, prod_u_hi, prod_u_lo,
    input  wb_valid, wb_hi, wb_lo, wb_tag,
    output wb_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_x, req0_y, req0_tag,
    output req0_ready,
    input  req1_valid, req1_op, req1_x, req1_y, req1_tag,
    output req1_ready,
    output mul_x, mul_y, mul_signed,
    input  prod_s_hi, prod_s_lo, prod_u_hi, prod_u_lo,
    output wb_valid, wb_hi, wb_lo, wb_tag,
    input  wb_ready
  );
endinterface

// File: rtl/mul_issue_arbiter.sv
// Shared MULT/MULTU issue arbiter: slot0>slot1 grant, LAT-deep tag line, result FIFO to writeback.
// Latency: grant -> wb_valid is LAT+1 cycles; one grant per cycle while credits remain.
// Backpressure: a result slot is reserved at grant; wb_ready low stalls grants once credits run out.
// Optional: define MUL_PERF_CNT_EN for perf_grants/perf_stall counters.
module mul_issue_arbiter #(
  parameter int LAT          = 6,
  parameter int RESULT_DEPTH = 4,
  parameter int TAG_W        = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  mul_issue_arbiter_if.slave bus
`ifdef MUL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_grants,
  output logic [31:0]       perf_stall
`endif
);

  // Opcode encodings shared with isa.h (MIPS funct field values)
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam int PTR_W = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESULT_DEPTH + 1);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             sgn;
    logic             known;
  } stage_t;

  typedef struct packed {
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [TAG_W-1:0] tag;
  } res_t;

  stage_t           dl_q [LAT];
  stage_t           dl_d [LAT];
  res_t             mem_q [RESULT_DEPTH];
  res_t             mem_d [RESULT_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d, count_q, count_d;
  logic             wb_valid_q, wb_valid_d;
  res_t             wb_q, wb_d;

  logic             can_issue, gnt0, gnt1, grant, push, pop;
  logic [5:0]       sel_op;
  logic [TAG_W-1:0] sel_tag;
  logic             op_known, op_signed;
  res_t             push_ent, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RESULT_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Grant selection and operand mux; the granted slot drives the multiplier this cycle
  always_comb begin
    can_issue = !reset && !flush && (count_q < CNT_W'(RESULT_DEPTH));
    gnt0      = bus.req0_valid && can_issue;
    gnt1      = bus.req1_valid && !bus.req0_valid && can_issue;
    grant     = gnt0 || gnt1;
    sel_op    = gnt0 ? bus.req0_op  : bus.req1_op;
    sel_tag   = gnt0 ? bus.req0_tag : bus.req1_tag;
    op_known  = grant && ((sel_op == OP_MULT) || (sel_op == OP_MULTU));
    op_signed = grant && (sel_op == OP_MULT);
    bus.req0_ready = gnt0;
    bus.req1_ready = gnt1;
    bus.mul_x      = gnt0 ? bus.req0_x : (gnt1 ? bus.req1_x : 32'h0);
    bus.mul_y      = gnt0 ? bus.req0_y : (gnt1 ? bus.req1_y : 32'h0);
    bus.mul_signed = op_signed;
  end

  // Delay line tracks each op alongside the multiplier pipe; flush kills every stage
  always_comb begin
    dl_d[0] = '{vld: grant, tag: grant ? sel_tag : '0, sgn: op_signed, known: op_known};
    for (int i = 1; i < LAT; i++) dl_d[i] = dl_q[i-1];
    if (flush) begin
      for (int i = 0; i < LAT; i++) dl_d[i].vld = 1'b0;
    end
  end

  // Result FIFO and credit count; head view is registered from the next-state FIFO
  always_comb begin
    push = dl_q[LAT-1].vld && !flush;
    pop  = wb_valid_q && bus.wb_ready;
    push_ent.tag = dl_q[LAT-1].tag;
    if (!dl_q[LAT-1].known) begin
      push_ent.hi = 32'h0;
      push_ent.lo = 32'h0;
    end else if (dl_q[LAT-1].sgn) begin
      push_ent.hi = bus.prod_s_hi;
      push_ent.lo = bus.prod_s_lo;
    end else begin
      push_ent.hi = bus.prod_u_hi;
      push_ent.lo = bus.prod_u_lo;
    end
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_ent;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    occ_d   = occ_q + CNT_W'(push) - CNT_W'(pop);
    count_d = count_q + CNT_W'(grant) - CNT_W'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      count_d  = '0;
    end
    head       = mem_d[rd_ptr_d];
    wb_valid_d = (occ_d != '0);
    wb_d       = wb_valid_d ? head : '0;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) dl_q[i] <= '0;
      for (int i = 0; i < RESULT_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
    end else begin
      dl_q       <= dl_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      count_q    <= count_d;
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_hi    = wb_q.hi;
  assign bus.wb_lo    = wb_q.lo;
  assign bus.wb_tag   = wb_q.tag;

  // Credits are reserved at grant, so a push into a full FIFO means the accounting broke
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (occ_q == CNT_W'(RESULT_DEPTH))));

`ifdef MUL_PERF_CNT_EN
  logic [31:0] perf_grants_q, perf_grants_d, perf_stall_q, perf_stall_d;
  logic        stall;

  // Count grants and credit-blocked request cycles; flush does not clear them
  always_comb begin
    stall = (bus.req0_valid || bus.req1_valid) && !reset && !flush &&
            (count_q >= CNT_W'(RESULT_DEPTH));
    perf_grants_d = perf_grants_q + 32'(grant);
    perf_stall_d  = perf_stall_q + 32'(stall);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grants_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_grants_q <= perf_grants_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_grants = perf_grants_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Directed bench for mul_issue_arbiter with a queue scoreboard and independent writeback monitor.
// Includes a behavioural 6-cycle multiplier that answers the operands the arbiter drives.
// Writeback readiness is driven by the stimulus to exercise credit stalls.
module tb_mul_issue_arbiter;
  localparam int TAG_W = 6;
  localparam int LAT   = 6;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;

  typedef struct packed {
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   nvec = 0;
  int   nerr = 0;
  exp_t exp_q[$];

  mul_issue_arbiter_if #(.TAG_W(TAG_W)) bus ();

`ifdef MUL_PERF_CNT_EN
  logic [31:0] perf_grants, perf_stall;
`endif

  mul_issue_arbiter #(.LAT(LAT), .RESULT_DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
`ifdef MUL_PERF_CNT_EN
    ,
    .perf_grants (perf_grants),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: products appear LAT cycles after operands
  logic [31:0] px [LAT];
  logic [31:0] py [LAT];
  logic [63:0] ps, pu;
  initial begin
    for (int i = 0; i < LAT; i++) begin
      px[i] = 32'h0;
      py[i] = 32'h0;
    end
  end
  always @(posedge clk) begin
    px[0] <= bus.mul_x;
    py[0] <= bus.mul_y;
    for (int i = 1; i < LAT; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
  end
  assign ps = {{32{px[LAT-1][31]}}, px[LAT-1]} * {{32{py[LAT-1][31]}}, py[LAT-1]};
  assign pu = {32'h0, px[LAT-1]} * {32'h0, py[LAT-1]};
  assign bus.prod_s_hi = ps[63:32];
  assign bus.prod_s_lo = ps[31:0];
  assign bus.prod_u_hi = pu[63:32];
  assign bus.prod_u_lo = pu[31:0];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic set_req(input int slot, input logic [5:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [TAG_W-1:0] tag, input logic v);
    if (slot == 0) begin
      bus.req0_op = op; bus.req0_x = x; bus.req0_y = y; bus.req0_tag = tag; bus.req0_valid = v;
    end else begin
      bus.req1_op = op; bus.req1_x = x; bus.req1_y = y; bus.req1_tag = tag; bus.req1_valid = v;
    end
  endtask

  // Called at a negedge; holds the request until granted or budget expires, returns at a negedge
  task automatic issue(input int slot, input logic [5:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [TAG_W-1:0] tag,
                       input logic [31:0] eh, input logic [31:0] el, output bit ok);
    ok = 1'b0;
    set_req(slot, op, x, y, tag, 1'b1);
    for (int c = 0; c < 20 && !ok; c++) begin
      #1;
      if ((slot == 0) ? bus.req0_ready : bus.req1_ready) begin
        ok = 1'b1;
        exp_q.push_back('{hi: eh, lo: el, tag: tag});
      end
      @(negedge clk);
    end
    set_req(slot, 6'h0, 32'h0, 32'h0, '0, 1'b0);
  endtask

  // Monitor: every accepted writeback is compared against the scoreboard head
  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bus.wb_valid && bus.wb_ready) begin
        got = '{hi: bus.wb_hi, lo: bus.wb_lo, tag: bus.wb_tag};
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL wb_unexpected: got %0h want no result", got);
        end else begin
          e = exp_q.pop_front();
          chk("wb_result", 128'(got), 128'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit ok;
    int lat;
    int k;
    bit exp_rdy [6];

    // Reset with a request pending: nothing may be granted or driven
    reset = 1'b1;
    flush = 1'b0;
    bus.wb_ready = 1'b0;
    set_req(1, 6'h0, 32'h0, 32'h0, '0, 1'b0);
    set_req(0, OP_MULT, 32'h1234, 32'h5678, 6'd3, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req0_ready", 128'(bus.req0_ready), 128'(0));
    chk("reset_wb_valid", 128'(bus.wb_valid), 128'(0));
    chk("reset_wb_data", 128'({bus.wb_hi, bus.wb_lo, bus.wb_tag}), 128'(0));
    chk("reset_mul", 128'({bus.mul_x, bus.mul_y, bus.mul_signed}), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    set_req(0, 6'h0, 32'h0, 32'h0, '0, 1'b0);
    bus.wb_ready = 1'b1;

    // Single signed op and its grant-to-writeback latency
    issue(0, OP_MULT, 32'hFFFFFFFD, 32'd5, 6'd7, 32'hFFFFFFFF, 32'hFFFFFFF1, ok);
    chk("t1_grant", 128'(ok), 128'(1));
    lat = 1;
    #2;
    while (!bus.wb_valid && lat < 20) begin
      @(negedge clk);
      #2;
      lat++;
    end
    chk("t1_latency", 128'(lat), 128'(7));
    @(negedge clk);
    repeat (3) @(negedge clk);

    // Both slots valid: slot 0 first, slot 1 the following cycle
    set_req(0, OP_MULTU, 32'd2, 32'd3, 6'd1, 1'b1);
    set_req(1, OP_MULT, 32'd4, 32'd5, 6'd2, 1'b1);
    #1;
    chk("t2_c0_ready0", 128'(bus.req0_ready), 128'(1));
    chk("t2_c0_ready1", 128'(bus.req1_ready), 128'(0));
    if (bus.req0_ready) exp_q.push_back('{hi: 32'h0, lo: 32'd6, tag: 6'd1});
    @(negedge clk);
    set_req(0, 6'h0, 32'h0, 32'h0, '0, 1'b0);
    #1;
    chk("t2_c1_ready1", 128'(bus.req1_ready), 128'(1));
    if (bus.req1_ready) exp_q.push_back('{hi: 32'h0, lo: 32'd20, tag: 6'd2});
    @(negedge clk);
    set_req(1, 6'h0, 32'h0, 32'h0, '0, 1'b0);
    repeat (12) @(negedge clk);
    chk("t2_drained", 128'(exp_q.size()), 128'(0));

    // Credit exhaustion with writeback blocked, from a fresh reset
    bus.wb_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      set_req(0, OP_MULTU, 32'(100 + k), 32'd3, 6'(10 + k), 1'b1);
      #1;
      if (bus.req0_ready) begin
        exp_q.push_back('{hi: 32'h0, lo: 32'(300 + 3 * k), tag: 6'(10 + k)});
        k++;
      end
      @(negedge clk);
    end
    #1;
    chk("t3_grants", 128'(k), 128'(4));
    chk("t3_blocked_ready", 128'(bus.req0_ready), 128'(0));
`ifdef MUL_PERF_CNT_EN
    chk("t6_perf_grants", 128'(perf_grants), 128'(4));
    chk("t6_perf_stall", 128'(perf_stall), 128'(8));
`endif
    // Release writeback: each pop frees a credit one cycle later
    exp_rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.wb_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      set_req(0, OP_MULTU, 32'(100 + k), 32'd3, 6'(10 + k), 1'b1);
      #1;
      chk($sformatf("t3_resume_ready_%0d", j), 128'(bus.req0_ready), 128'(exp_rdy[j]));
      if (bus.req0_ready) begin
        exp_q.push_back('{hi: 32'h0, lo: 32'(300 + 3 * k), tag: 6'(10 + k)});
        k++;
      end
      @(negedge clk);
    end
    set_req(0, 6'h0, 32'h0, 32'h0, '0, 1'b0);
    repeat (15) @(negedge clk);
    chk("t3_drained", 128'(exp_q.size()), 128'(0));

    // Flush with three ops in flight: none of them may reach writeback
    for (int j = 0; j < 3; j++) begin
      issue(0, OP_MULT, 32'(50 + j), 32'd2, 6'(20 + j), 32'h0, 32'(100 + 2 * j), ok);
      chk("t4_pre_grant", 128'(ok), 128'(1));
    end
    flush = 1'b1;
    exp_q.delete();
    set_req(0, OP_MULT, 32'd7, 32'hFFFFFFFE, 6'd30, 1'b1);
    #1;
    chk("t4_flush_no_grant", 128'(bus.req0_ready), 128'(0));
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("t4_post_flush_grant", 128'(bus.req0_ready), 128'(1));
    if (bus.req0_ready) exp_q.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF2, tag: 6'd30});
    @(negedge clk);
    set_req(0, 6'h0, 32'h0, 32'h0, '0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      #2;
      chk("t4_killed_quiet", 128'(bus.wb_valid), 128'(0));
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("t4_drained", 128'(exp_q.size()), 128'(0));

    // Operand and opcode boundaries
    issue(0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd40, 32'hFFFFFFFE, 32'h00000001, ok);
    chk("t5_grant_a", 128'(ok), 128'(1));
    issue(0, 6'h00, 32'd5, 32'd6, 6'd41, 32'h0, 32'h0, ok);
    chk("t5_grant_b", 128'(ok), 128'(1));
    issue(1, OP_MULT, 32'h80000000, 32'h80000000, 6'd42, 32'h40000000, 32'h0, ok);
    chk("t5_grant_c", 128'(ok), 128'(1));
    repeat (14) @(negedge clk);
    chk("t5_drained", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
